// File: rtl/ram_tx_sequencer.sv
// ----------------------------------------------------------------------------
// ram_tx_sequencer
//
// Purpose:
//   Owns the 8-bit DRAM port and the UART transmitter handshake. On start it
//   first fills DRAM addresses 0..DEPTH-1 with an incrementing byte pattern
//   beginning at seed, then reads every location back and hands each byte to
//   the transmitter. Fill and send are strictly sequenced and never overlap.
//
// Parameters:
//   ADDR_W  - DRAM address width
//   DEPTH   - number of locations filled and sent (1..2^ADDR_W)
//   RD_LAT  - DRAM read latency in clocks (1 or 2)
//   BUSY_TO - clocks allowed for tx_busy_i to rise after tx_start_o
//
// Ports:
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   start_i      begin a fill/send run (sampled only in IDLE/DONE)
//   abort_i      synchronous abort, returns to IDLE next clock
//   seed_i       data value written at address 0
//   ram_addr_o   DRAM address
//   ram_wdata_o  DRAM write data
//   ram_wren_o   DRAM write enable
//   ram_q_i      DRAM read data
//   tx_data_o    byte presented to the transmitter
//   tx_start_o   one-clock transmit request
//   tx_busy_i    transmitter busy flag
//   busy_o       high in any state other than IDLE/DONE
//   done_o       high in DONE until the next start
//   tx_err_o     sticky handshake-timeout flag, cleared on start
//   state_out_o  state encoding for debug
// ----------------------------------------------------------------------------
module ram_tx_sequencer #(
    parameter int ADDR_W  = 16,
    parameter int DEPTH   = 256,
    parameter int RD_LAT  = 1,
    parameter int BUSY_TO = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_i,
    input  logic              abort_i,
    input  logic [7:0]        seed_i,
    output logic [ADDR_W-1:0] ram_addr_o,
    output logic [7:0]        ram_wdata_o,
    output logic              ram_wren_o,
    input  logic [7:0]        ram_q_i,
    output logic [7:0]        tx_data_o,
    output logic              tx_start_o,
    input  logic              tx_busy_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              tx_err_o,
    output logic [2:0]        state_out_o
);

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_FILL       = 3'd1,
        ST_RD_REQ     = 3'd2,
        ST_RD_WAIT    = 3'd3,
        ST_TX_LOAD    = 3'd4,
        ST_TX_WAIT_HI = 3'd5,
        ST_TX_WAIT_LO = 3'd6,
        ST_DONE       = 3'd7
    } state_e;

    localparam int                TO_W      = $clog2(BUSY_TO + 1);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [1:0]        LAT_LAST  = 2'(RD_LAT - 1);
    localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(BUSY_TO - 1);

    state_e              state_q,    state_d;
    logic [ADDR_W-1:0]   addr_q,     addr_d;
    logic [7:0]          wdata_q,    wdata_d;
    logic                wren_q,     wren_d;
    logic [7:0]          tx_data_q,  tx_data_d;
    logic                tx_start_q, tx_start_d;
    logic                tx_err_q,   tx_err_d;
    logic                done_q,     done_d;
    logic                busy_q,     busy_d;
    logic [1:0]          lat_q,      lat_d;
    logic [TO_W-1:0]     to_q,       to_d;

    // Next-state and registered-output computation for the sequencer.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        wren_d     = 1'b0;
        tx_data_d  = tx_data_q;
        tx_start_d = 1'b0;
        tx_err_d   = tx_err_q;
        lat_d      = lat_q;
        to_d       = to_q;

        if (abort_i) begin
            // Write enable and transmit request fall with the return to IDLE;
            // tx_err is deliberately kept so the fault stays visible.
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (start_i) begin
                        state_d  = ST_FILL;
                        addr_d   = '0;
                        wdata_d  = seed_i;
                        wren_d   = 1'b1;
                        tx_err_d = 1'b0;
                    end else begin
                        state_d = state_q;
                    end
                end
                ST_FILL: begin
                    // The cycle presenting LAST_ADDR is the final write.
                    if (addr_q == LAST_ADDR) begin
                        state_d = ST_RD_REQ;
                        addr_d  = '0;
                    end else begin
                        addr_d  = addr_q + ADDR_W'(1);
                        wdata_d = wdata_q + 8'd1;
                        wren_d  = 1'b1;
                    end
                end
                ST_RD_REQ: begin
                    state_d = ST_RD_WAIT;
                    lat_d   = 2'd0;
                end
                ST_RD_WAIT: begin
                    if (lat_q >= LAT_LAST) begin
                        tx_data_d = ram_q_i;
                        state_d   = ST_TX_LOAD;
                    end else begin
                        lat_d = lat_q + 2'd1;
                    end
                end
                ST_TX_LOAD: begin
                    // The request is raised while still in TX_LOAD and the
                    // state advances once it has been visible for one clock.
                    if (tx_start_q) begin
                        state_d = ST_TX_WAIT_HI;
                        to_d    = to_q + TO_W'(1);
                    end else if (!tx_busy_i) begin
                        tx_start_d = 1'b1;
                        to_d       = '0;
                    end else begin
                        state_d = ST_TX_LOAD;
                    end
                end
                ST_TX_WAIT_HI: begin
                    // to_q counts clocks since tx_start_o rose.
                    if (tx_busy_i) begin
                        state_d = ST_TX_WAIT_LO;
                    end else if (to_q >= TO_LAST) begin
                        tx_err_d = 1'b1;
                        state_d  = ST_TX_WAIT_LO;
                    end else begin
                        to_d = to_q + TO_W'(1);
                    end
                end
                ST_TX_WAIT_LO: begin
                    if (!tx_busy_i) begin
                        if (addr_q == LAST_ADDR) begin
                            state_d = ST_DONE;
                        end else begin
                            addr_d  = addr_q + ADDR_W'(1);
                            state_d = ST_RD_REQ;
                        end
                    end else begin
                        state_d = ST_TX_WAIT_LO;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        done_d = (state_d == ST_DONE);
        busy_d = (state_d != ST_IDLE) && (state_d != ST_DONE);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            wdata_q    <= 8'd0;
            wren_q     <= 1'b0;
            tx_data_q  <= 8'd0;
            tx_start_q <= 1'b0;
            tx_err_q   <= 1'b0;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
            lat_q      <= 2'd0;
            to_q       <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            wren_q     <= wren_d;
            tx_data_q  <= tx_data_d;
            tx_start_q <= tx_start_d;
            tx_err_q   <= tx_err_d;
            done_q     <= done_d;
            busy_q     <= busy_d;
            lat_q      <= lat_d;
            to_q       <= to_d;
        end
    end

    assign ram_addr_o  = addr_q;
    assign ram_wdata_o = wdata_q;
    assign ram_wren_o  = wren_q;
    assign tx_data_o   = tx_data_q;
    assign tx_start_o  = tx_start_q;
    assign tx_err_o    = tx_err_q;
    assign done_o      = done_q;
    assign busy_o      = busy_q;
    assign state_out_o = state_q;

endmodule
